// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: default register-bank geometry, the zero
// register index and the dump engine state encoding.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;

  // Register 0 is architecturally hardwired to zero.
  localparam int REG_ZERO = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dump_state_e;

  // True when a register index addresses the hardwired zero register.
  function automatic logic is_reg_zero(input int unsigned idx);
    return (idx == 32'(REG_ZERO));
  endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Bundle of the register-file access ports and the debug dump stream.
// The core/testbench side uses the master modport, the register file the slave.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2
);
  localparam int AW = $clog2(NREGS);

  // Write port
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [DATA_W-1:0]     wdata;
  // Combinational read ports, port i at [i*AW +: AW] / [i*DATA_W +: DATA_W]
  logic [NRD*AW-1:0]     raddr;
  logic [NRD*DATA_W-1:0] rdata;
  // Dump stream
  logic                  dump_start;
  logic                  dump_busy;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [AW-1:0]         dump_addr;
  logic [DATA_W-1:0]     dump_data;
  logic                  dump_last;

  modport master (
    output we, waddr, wdata, raddr, dump_start, dump_ready,
    input  rdata, dump_busy, dump_valid, dump_addr, dump_data, dump_last
  );

  modport slave (
    input  we, waddr, wdata, raddr, dump_start, dump_ready,
    output rdata, dump_busy, dump_valid, dump_addr, dump_data, dump_last
  );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks a pointer over every register index and presents one
// beat per index on a valid/ready channel. Register contents are muxed in by
// the parent from the pointer this block exposes.
module regfile_dump_ctrl
  import mips_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_start,
  input  logic          dump_ready,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic          dump_last
);

  localparam logic [0:0]    ST_IDLE   = IDLE;
  localparam logic [0:0]    ST_RUN    = RUN;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  logic [0:0]    state_r;
  logic [0:0]    state_nxt_s;
  logic [AW-1:0] ptr_r;
  logic [AW-1:0] ptr_nxt_s;
  logic [AW-1:0] ptr_inc_s;
  logic          last_r;
  logic          last_nxt_s;

  assign ptr_inc_s = ptr_r + AW'(1);

  // Next-state decode: start is only honoured from IDLE; an accepted final beat returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (dump_start) begin
          state_nxt_s = ST_RUN;
          ptr_nxt_s   = '0;
          last_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (dump_ready) begin
          if (last_r) begin
            state_nxt_s = ST_IDLE;
            ptr_nxt_s   = '0;
            last_nxt_s  = 1'b0;
          end else begin
            ptr_nxt_s  = ptr_inc_s;
            last_nxt_s = (ptr_inc_s == LAST_ADDR);
          end
        end else begin
          // Stalled: hold the current beat.
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = '0;
        last_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, pointer and last-beat flag registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  assign dump_busy  = (state_r == ST_RUN);
  assign dump_valid = (state_r == ST_RUN);
  assign dump_addr  = ptr_r;
  assign dump_last  = last_r;

endmodule

// File: rtl/regfile_dump.sv
// MIPS register file: NRD combinational read ports, one write port, optional
// write-to-read forwarding, register 0 hardwired to zero, and a dump engine
// that streams every register out over a valid/ready channel.
module regfile_dump
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_dump_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0]     regs_r [NREGS];
  logic [NRD*DATA_W-1:0] rdata_s;
  logic [AW-1:0]         dump_addr_s;
  logic                  wr_en_s;

  // Writes to the zero register are dropped so it never holds anything but 0.
  assign wr_en_s = bus.we && !is_reg_zero(32'(bus.waddr));

  // Register storage: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[bus.waddr] <= bus.wdata;
    end
  end

  // Read ports: zero register first, then same-cycle forwarding, then storage.
  always_comb begin
    rdata_s = '0;
    for (int p = 0; p < NRD; p++) begin
      if (is_reg_zero(32'(bus.raddr[p*AW +: AW]))) begin
        rdata_s[p*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && bus.we && (bus.waddr == bus.raddr[p*AW +: AW])) begin
        rdata_s[p*DATA_W +: DATA_W] = bus.wdata;
      end else begin
        rdata_s[p*DATA_W +: DATA_W] = regs_r[bus.raddr[p*AW +: AW]];
      end
    end
  end

  assign bus.rdata = rdata_s;

  regfile_dump_ctrl #(
    .NREGS(NREGS)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .dump_start (bus.dump_start),
    .dump_ready (bus.dump_ready),
    .dump_busy  (bus.dump_busy),
    .dump_valid (bus.dump_valid),
    .dump_addr  (dump_addr_s),
    .dump_last  (bus.dump_last)
  );

  assign bus.dump_addr = dump_addr_s;
  // Dump data tracks the live register (no forwarding), so a write during a
  // stall is seen on the following cycle.
  assign bus.dump_data = regs_r[dump_addr_s];

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table-driven read/write vectors and a
// queue-based scoreboard for the dump stream (full, backpressured, aborted).
module tb_regfile_dump;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_dump_if #(.DATA_W(DW), .NREGS(NR), .NRD(2)) bus ();
  regfile_dump_if #(.DATA_W(DW), .NREGS(8),  .NRD(2)) nb ();

  regfile_dump #(.DATA_W(DW), .NREGS(NR), .NRD(2), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  regfile_dump #(.DATA_W(DW), .NREGS(8), .NRD(2), .BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (nb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  typedef struct {
    int          addr;
    logic [DW-1:0] data;
    logic        last;
  } beat_t;

  vec_t          vt [11];
  beat_t         q [$];
  logic [DW-1:0] model [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Runs one dump. stall_addr >= 0 stalls 3 cycles there and rewrites that
  // register to 99; abort_addr >= 0 asserts reset when that beat is presented.
  task automatic run_dump(input int stall_addr, input int abort_addr);
    int    busy_cnt;
    int    stalls;
    bit    aborted;
    beat_t b;
    busy_cnt = 0;
    stalls   = 0;
    aborted  = 1'b0;
    q.delete();
    for (int a = 0; a < NR; a++) begin
      b.addr = a;
      b.data = model[a];
      b.last = (a == NR - 1);
      q.push_back(b);
    end
    bus.dump_start = 1'b1;
    bus.dump_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.dump_start = 1'b0;
    for (int cyc = 0; cyc < 400 && q.size() > 0 && !aborted; cyc++) begin
      @(negedge clk);
      bus.we = 1'b0;
      if (bus.dump_busy) busy_cnt++;
      if (bus.dump_valid && int'(bus.dump_addr) == abort_addr) begin
        rst = 1'b1;
        bus.raddr = {5'd3, 5'd1};
        #1;
        chk("abort_busy", 64'(bus.dump_busy), 64'd0);
        chk("abort_valid", 64'(bus.dump_valid), 64'd0);
        chk("abort_addr", 64'(bus.dump_addr), 64'd0);
        chk("abort_data", 64'(bus.dump_data), 64'd0);
        chk("abort_rdata", 64'(bus.rdata), 64'd0);
        for (int a = 0; a < NR; a++) model[a] = '0;
        q.delete();
        aborted = 1'b1;
        #1;
        rst = 1'b0;
      end else if (bus.dump_valid && int'(bus.dump_addr) == stall_addr && stalls < 3) begin
        bus.dump_ready = 1'b0;
        stalls++;
        chk("stall_addr", 64'(bus.dump_addr), 64'(stall_addr));
        if (stalls == 1) begin
          bus.we    = 1'b1;
          bus.waddr = AW'(stall_addr);
          bus.wdata = 32'd99;
          model[stall_addr] = 32'd99;
          foreach (q[k]) if (q[k].addr == stall_addr) q[k].data = 32'd99;
        end
      end else begin
        bus.dump_ready = 1'b1;
        if (bus.dump_valid) begin
          b = q.pop_front();
          chk("beat_addr", 64'(bus.dump_addr), 64'(b.addr));
          chk("beat_data", 64'(bus.dump_data), 64'(b.data));
          chk("beat_last", 64'(bus.dump_last), 64'(b.last));
        end
      end
    end
    if (!aborted) begin
      chk("dump_drained", 64'(q.size()), 64'd0);
      chk("busy_cycles", 64'(busy_cnt), 64'(NR + stalls));
      @(negedge clk);
      chk("post_valid", 64'(bus.dump_valid), 64'd0);
      chk("post_busy", 64'(bus.dump_busy), 64'd0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    nb.we = 1'b0; nb.waddr = '0; nb.wdata = '0; nb.raddr = '0;
    nb.dump_start = 1'b0; nb.dump_ready = 1'b0;
    for (int a = 0; a < NR; a++) model[a] = '0;

    //                 we    waddr  wdata          ra0    ra1    e0             e1
    vt[0]  = '{1'b1, 5'd1, 32'd5,          5'd1,  5'd0,  32'd5,          32'd0};
    vt[1]  = '{1'b1, 5'd2, 32'd7,          5'd1,  5'd2,  32'd5,          32'd7};
    vt[2]  = '{1'b1, 5'd3, 32'd12,         5'd2,  5'd3,  32'd7,          32'd12};
    vt[3]  = '{1'b0, 5'd0, 32'd0,          5'd1,  5'd3,  32'd5,          32'd12};
    vt[4]  = '{1'b0, 5'd0, 32'd0,          5'd2,  5'd2,  32'd7,          32'd7};
    vt[5]  = '{1'b1, 5'd0, 32'hDEADBEEF,   5'd0,  5'd0,  32'd0,          32'd0};
    vt[6]  = '{1'b0, 5'd0, 32'd0,          5'd0,  5'd1,  32'd0,          32'd5};
    vt[7]  = '{1'b1, 5'd4, 32'h55,         5'd4,  5'd4,  32'h55,         32'h55};
    vt[8]  = '{1'b0, 5'd0, 32'd0,          5'd4,  5'd5,  32'h55,         32'd0};
    vt[9]  = '{1'b1, 5'd4, 32'h66,         5'd4,  5'd3,  32'h66,         32'd12};
    vt[10] = '{1'b0, 5'd0, 32'd0,          5'd4,  5'd31, 32'h66,         32'd0};

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(bus.dump_busy), 64'd0);
    chk("rst_valid", 64'(bus.dump_valid), 64'd0);
    chk("rst_last", 64'(bus.dump_last), 64'd0);
    chk("rst_addr", 64'(bus.dump_addr), 64'd0);
    chk("rst_data", 64'(bus.dump_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Read/write vectors: checked before the edge that commits the write
    for (int v = 0; v < 11; v++) begin
      bus.we    = vt[v].we;
      bus.waddr = vt[v].waddr;
      bus.wdata = vt[v].wdata;
      bus.raddr = {vt[v].ra1, vt[v].ra0};
      if (vt[v].we && vt[v].waddr != 5'd0) model[vt[v].waddr] = vt[v].wdata;
      #1;
      chk($sformatf("vec%0d_rd0", v), 64'(bus.rdata[31:0]), 64'(vt[v].e0));
      chk($sformatf("vec%0d_rd1", v), 64'(bus.rdata[63:32]), 64'(vt[v].e1));
      @(negedge clk);
    end
    bus.we = 1'b0;

    // No forwarding: old value before the edge, new value after it
    nb.we = 1'b1; nb.waddr = 3'd4; nb.wdata = 32'h55; nb.raddr = {3'd0, 3'd4};
    #1;
    chk("nobyp_before", 64'(nb.rdata[31:0]), 64'd0);
    @(negedge clk);
    nb.we = 1'b0;
    #1;
    chk("nobyp_after", 64'(nb.rdata[31:0]), 64'h55);
    chk("nobyp_zero", 64'(nb.rdata[63:32]), 64'd0);
    @(negedge clk);

    // Full dump, ready held high
    run_dump(-1, -1);
    @(negedge clk);
    // Backpressure at addr 2 with a write to r2 during the stall
    run_dump(2, -1);
    @(negedge clk);
    // Asynchronous reset mid-dump, then a fresh all-zero dump
    run_dump(-1, 10);
    @(negedge clk);
    run_dump(-1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
